// File: rtl/bus_pkg.sv
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared size codes, FSM encoding and lane helpers for the core bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Illegal sizes report 4 bytes; they are flagged as errors separately.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_lane.sv
// ============================================================================
// Module  : sram_lane
// Brief   : One byte-wide synchronous RAM lane, write-first registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(2**AW)-1];
  logic [7:0] r_q;

  // Write-first so a write response can return the post-write word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_q           <= i_wdata;
    end else begin
      r_q           <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/bus_sram_slave.sv
// ============================================================================
// Module  : bus_sram_slave
// Brief   : Core-bus SRAM slave with wait states, range checks and back door.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_sram_slave
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h0000_1000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  input  logic        dbg_en,
  input  logic        dbg_wr,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);

  localparam int         c_WORDS     = DEPTH / 4;
  localparam int         c_AW        = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
  localparam logic [3:0] c_LAST      = 4'(WAIT_STATES - 1);
  localparam bit         c_ZERO_WAIT = (WAIT_STATES == 0);

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [2:0]      r_size;
  logic            r_write;
  logic            r_err;
  logic [3:0]      r_cnt;
  logic            r_dbg_done;
  logic [31:0]     r_rdata_hold;
  logic [31:0]     r_dbg_hold;

  logic            w_open;
  logic            w_accept;
  logic            w_dbg_go;
  logic            w_req_err;
  logic [c_AW-1:0] w_idx;
  logic [3:0]      w_we;
  logic [31:0]     w_wd;
  logic [31:0]     w_q;
  logic [31:0]     w_resp;

  function automatic logic req_err(input logic [31:0] a, input logic [2:0] sz);
    logic [2:0]  nb;
    logic [32:0] off_end;
    nb      = size_bytes(sz);
    off_end = {1'b0, a - BASE} + 33'(nb);
    return (a < BASE) || (off_end > 33'(DEPTH)) ||
           (({1'b0, a[1:0]} + nb) > 3'd4) || (sz > SZ_WORD);
  endfunction

  // The back door owns the RAM port whenever it asks in an open cycle.
  assign w_open    = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_dbg_go  = w_open && dbg_en;
  assign w_accept  = w_open && valid && !dbg_en;
  assign w_req_err = req_err(addr, size);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = c_ZERO_WAIT ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == c_LAST) w_next = ST_RESP;
      ST_RESP: begin
        if (w_accept) w_next = c_ZERO_WAIT ? ST_RESP : ST_WAIT;
        else          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_dbg_done   <= 1'b0;
      r_rdata_hold <= '0;
      r_dbg_hold   <= '0;
    end else begin
      r_state    <= w_next;
      r_dbg_done <= w_dbg_go;
      if (w_accept) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_size  <= size;
        r_write <= write;
        r_err   <= w_req_err;
        r_cnt   <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt   <= r_cnt + 4'd1;
      end
      if (r_state == ST_RESP) r_rdata_hold <= w_resp;
      if (r_dbg_done)         r_dbg_hold   <= w_q;
    end
  end

  // RAM port mux: captured request in WAIT, else back door, else live core.
  always_comb begin
    w_idx = c_AW'((addr - BASE) >> 2);
    w_wd  = wdata << {addr[1:0], 3'b000};
    w_we  = 4'b0000;
    if (r_state == ST_WAIT) begin
      w_idx = c_AW'((r_addr - BASE) >> 2);
      w_wd  = r_wdata << {r_addr[1:0], 3'b000};
      if ((r_cnt == 4'd0) && r_write && !r_err) w_we = lane_mask(r_size, r_addr[1:0]);
    end else if (dbg_en) begin
      w_idx = c_AW'((dbg_addr - BASE) >> 2);
      w_wd  = dbg_wdata;
      if (dbg_wr) w_we = 4'b1111;
    end else if (w_accept && c_ZERO_WAIT && write && !w_req_err) begin
      w_we  = lane_mask(size, addr[1:0]);
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    sram_lane #(.AW(c_AW)) u_lane (
      .clk     (clk),
      .i_we    (w_we[gi]),
      .i_addr  (w_idx),
      .i_wdata (w_wd[8*gi +: 8]),
      .o_rdata (w_q[8*gi +: 8])
    );
  end

  assign w_resp    = (r_err && !r_write) ? ERR_DATA : w_q;
  assign ready     = (r_state == ST_RESP);
  assign err       = ready && r_err;
  assign rdata     = ready ? w_resp : r_rdata_hold;
  assign dbg_rdata = r_dbg_done ? w_q : r_dbg_hold;

endmodule

`default_nettype wire
